// File: rtl/rv_core_pkg.sv
// Shared core-wide constants and the operand-fetch FSM state type.
package rv_core_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } of_state_t;

endpackage

// File: rtl/scoreboard.sv
// Register busy-bit scoreboard: tracks in-flight writers and flags RAW hazards,
// treating a same-cycle writeback as already resolved.
module scoreboard
    import rv_core_pkg::REG_IDX_W;
#(
    parameter int NREG = rv_core_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 use1,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic                 use2,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 hazard
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    function automatic logic src_blocked(input logic                 use_it,
                                         input logic [REG_IDX_W-1:0] idx,
                                         input logic [NREG-1:0]      bits,
                                         input logic                 wb_en,
                                         input logic [REG_IDX_W-1:0] wb_idx);
        if (!use_it || idx == '0 || int'(idx) >= NREG) return 1'b0;
        return bits[idx] && !(wb_en && wb_idx == idx);
    endfunction

    assign hazard = src_blocked(use1, rs1, busy, clr_en, clr_idx) ||
                    src_blocked(use2, rs2, busy, clr_en, clr_idx);

    // Clear first, then set: a new writer wins over a retiring one on the same index.
    always_comb begin
        busy_next = busy;
        if (clr_en && int'(clr_idx) < NREG) busy_next[clr_idx] = 1'b0;
        if (set_en && int'(set_idx) < NREG) busy_next[set_idx] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards same-cycle writeback,
// stalls on scoreboard hazards and hands one operand pair per cycle to execute.
module operand_fetch
    import rv_core_pkg::REG_IDX_W, rv_core_pkg::of_state_t,
           rv_core_pkg::EMPTY, rv_core_pkg::FULL, rv_core_pkg::STALL;
#(
    parameter int XLEN = rv_core_pkg::XLEN,
    parameter int NREG = rv_core_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic                 in_rd_we,
    input  logic [31:0]          in_instr,
    output logic                 rd_en1,
    output logic                 rd_en2,
    output logic [REG_IDX_W-1:0] rd_index1,
    output logic [REG_IDX_W-1:0] rd_index2,
    input  logic [XLEN-1:0]      rd_data1,
    input  logic [XLEN-1:0]      rd_data2,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_index,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_we,
    output logic [31:0]          out_instr,
    output logic [15:0]          stall_count,
    output of_state_t            fsm_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both
    // high. A producer holding valid keeps its payload stable until that edge; ready
    // may depend combinationally on valid-side state but valid never depends on ready.

    logic            hazard;
    logic            accept;
    logic            set_en;
    logic [XLEN-1:0] op1_res;
    logic [XLEN-1:0] op2_res;

    function automatic logic [XLEN-1:0] resolve(input logic                 use_it,
                                                input logic [REG_IDX_W-1:0] idx,
                                                input logic [XLEN-1:0]      rf_data,
                                                input logic                 fwd_en,
                                                input logic [REG_IDX_W-1:0] fwd_idx,
                                                input logic [XLEN-1:0]      fwd_data);
        if (!use_it || idx == '0) return '0;
        if (fwd_en && fwd_idx == idx) return fwd_data;
        return rf_data;
    endfunction

    assign rd_en1    = in_valid & in_use_rs1;
    assign rd_en2    = in_valid & in_use_rs2;
    assign rd_index1 = in_rs1;
    assign rd_index2 = in_rs2;

    assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign set_en   = accept & in_rd_we & (in_rd != '0);

    assign op1_res = resolve(in_use_rs1, in_rs1, rd_data1, wb_en, wb_index, wb_data);
    assign op2_res = resolve(in_use_rs2, in_rs2, rd_data2, wb_en, wb_index, wb_data);

    scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .set_en  (set_en),
        .set_idx (in_rd),
        .clr_en  (wb_en),
        .clr_idx (wb_index),
        .use1    (in_use_rs1),
        .rs1     (in_rs1),
        .use2    (in_use_rs2),
        .rs2     (in_rs2),
        .hazard  (hazard)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state   <= EMPTY;
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_instr   <= '0;
            stall_count <= '0;
        end else begin
            if (in_valid && hazard && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;

            if (flush) begin
                fsm_state <= EMPTY;
                out_valid <= 1'b0;
            end else if (accept) begin
                fsm_state <= FULL;
                out_valid <= 1'b1;
                out_op1   <= op1_res;
                out_op2   <= op2_res;
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
                out_instr <= in_instr;
            end else if (out_valid && !out_ready) begin
                fsm_state <= FULL;
            end else begin
                // Output drained (or never held): park in STALL while a hazard blocks.
                fsm_state <= (in_valid && hazard) ? STALL : EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_operand_fetch;
    import rv_core_pkg::*;

    localparam int W = 102;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_use_rs1 = 1'b0, in_use_rs2 = 1'b0, in_rd_we = 1'b0;
    logic [31:0] in_instr = '0;
    logic        rd_en1, rd_en2;
    logic [4:0]  rd_index1, rd_index2;
    logic [31:0] rd_data1, rd_data2;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_index = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_instr;
    logic [15:0] stall_count;
    of_state_t   fsm_state;

    logic [31:0] rf [32];
    assign rd_data1 = rf[rd_index1];
    assign rd_data2 = rf[rd_index2];

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd_we(in_rd_we),
        .in_instr(in_instr),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_index1(rd_index1), .rd_index2(rd_index2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_instr(out_instr), .stall_count(stall_count), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0] exp_q[$];
    logic [31:0]  busy_m;
    int           stall_m;
    of_state_t    st_m;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, we;
        logic [31:0] instr;
        logic        wbe;
        logic [4:0]  wbi;
        logic [31:0] wbd;
        logic        ordy;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic u1, logic u2, logic we, logic [31:0] instr,
                                logic wbe, logic [4:0] wbi, logic [31:0] wbd,
                                logic ordy, logic exp_ready);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.we = we;
        r.instr = instr; r.wbe = wbe; r.wbi = wbi; r.wbd = wbd; r.ordy = ordy;
        r.exp_ready = exp_ready;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic blocked(input logic use_it, input logic [4:0] idx);
        return use_it && idx != 0 && busy_m[idx] && !(wb_en && wb_index == idx);
    endfunction

    function automatic logic [31:0] op_m(input logic use_it, input logic [4:0] idx);
        if (!use_it || idx == 0) return 32'd0;
        if (wb_en && wb_index == idx) return wb_data;
        return rf[idx];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy_m  = '0;
        stall_m = 0;
        st_m    = EMPTY;
    endtask

    // One clock: check DUT against the model at negedge, advance model, cross posedge.
    task automatic cycle();
        logic haz, rdy, acc;
        @(negedge clk);
        haz = blocked(in_use_rs1, in_rs1) || blocked(in_use_rs2, in_rs2);
        rdy = !haz && (exp_q.size() == 0 || out_ready) && !flush;
        acc = in_valid && rdy;
        check("in_ready", in_ready, rdy);
        check("rd_en1", rd_en1, in_valid & in_use_rs1);
        check("rd_en2", rd_en2, in_valid & in_use_rs2);
        check("rd_index1", rd_index1, in_rs1);
        check("rd_index2", rd_index2, in_rs2);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check("out_fields", {out_op1, out_op2, out_rd, out_rd_we, out_instr}, exp_q[0]);
        check("stall_count", stall_count, stall_m);
        check("fsm_state", fsm_state, st_m);

        if (in_valid && haz && stall_m < 65535) stall_m++;
        if (flush) begin
            exp_q.delete();
            busy_m = '0;
            st_m   = EMPTY;
        end else begin
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (acc)
                exp_q.push_back({op_m(in_use_rs1, in_rs1), op_m(in_use_rs2, in_rs2),
                                 in_rd, in_rd_we, in_instr});
            if (wb_en) busy_m[wb_index] = 1'b0;
            if (acc && in_rd_we && in_rd != 0) busy_m[in_rd] = 1'b1;
            busy_m[0] = 1'b0;
            st_m = (exp_q.size() != 0) ? FULL : ((in_valid && haz) ? STALL : EMPTY);
        end
        if (wb_en && wb_index != 0) rf[wb_index] = wb_data;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_op(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic we, input logic [31:0] instr);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_rs1 = u1; in_use_rs2 = u2; in_rd_we = we; in_instr = instr;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] idx, input logic [31:0] data);
        wb_en = en; wb_index = idx; wb_data = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        rf[0] = '0;
        model_reset();

        // reset state
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_op1", out_op1, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_stall_count", stall_count, 16'd0);
        check("rst_fsm_state", fsm_state, EMPTY);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // directed table: independent ops, RAW stall, same-cycle set/clear, x0 source
        vecs[0]  = mk(1, 1, 2, 3, 1, 1, 1, 32'h002081B3, 0, 0, 0, 1, 1);
        vecs[1]  = mk(1, 1, 2, 4, 1, 1, 1, 32'h00208233, 0, 0, 0, 1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 3, 32'h0000_0033, 1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 4, 32'h0000_0044, 1, 1);
        vecs[4]  = mk(1, 1, 2, 5, 1, 1, 1, 32'h002082B3, 0, 0, 0, 1, 1);
        vecs[5]  = mk(1, 5, 0, 6, 1, 0, 0, 32'h00028313, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 5, 0, 6, 1, 0, 0, 32'h00028313, 0, 0, 0, 1, 0);
        vecs[7]  = mk(1, 5, 0, 6, 1, 0, 0, 32'h00028313, 0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 5, 0, 6, 1, 0, 0, 32'h00028313, 1, 5, 32'hCAFE_0005, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1);
        vecs[10] = mk(1, 1, 0, 7, 1, 0, 1, 32'h00008393, 0, 0, 0, 1, 1);
        vecs[11] = mk(1, 2, 0, 7, 1, 0, 1, 32'h00010393, 1, 7, 32'h0000_0777, 1, 1);
        vecs[12] = mk(1, 7, 0, 8, 1, 0, 0, 32'h00038413, 0, 0, 0, 1, 0);
        vecs[13] = mk(1, 7, 0, 8, 1, 0, 0, 32'h00038413, 1, 7, 32'h0000_0707, 1, 1);
        vecs[14] = mk(1, 0, 0, 9, 1, 1, 1, 32'h000004B3, 1, 0, 32'hDEAD_BEEF, 1, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1);

        for (int i = 0; i < 16; i++) begin
            drive_op(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                     vecs[i].u1, vecs[i].u2, vecs[i].we, vecs[i].instr);
            drive_wb(vecs[i].wbe, vecs[i].wbi, vecs[i].wbd);
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
            cycle();
            if (i == 0) check("indep_op1", out_op1, 32'h1001_0101);
            if (i == 8) begin
                check("raw_stall_count", stall_count, 16'd3);
                check("raw_fwd_op1", out_op1, 32'hCAFE_0005);
            end
            if (i == 14) begin
                check("x0_op1", out_op1, 32'd0);
                check("x0_op2", out_op2, 32'd0);
            end
        end

        // back-pressure for 4 cycles while FULL, then flush
        drive_wb(0, 0, 0);
        out_ready = 1'b1;
        drive_op(1, 1, 2, 10, 1, 1, 1, 32'h00208533);
        cycle();
        out_ready = 1'b0;
        drive_op(1, 3, 4, 12, 1, 1, 1, 32'h00418633);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_op1", out_op1, 32'h1001_0101);
            check("bp_out_op2", out_op2, 32'h1002_0202);
            check("bp_out_rd", out_rd, 5'd10);
            cycle();
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        cycle();
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        drive_op(1, 10, 9, 13, 1, 1, 0, 32'h009506B3);
        #1;
        check("flush_busy_clear", in_ready, 1'b1);
        cycle();

        // async reset while FULL with busy bits set
        drive_op(1, 1, 0, 11, 1, 0, 1, 32'h00008593);
        cycle();
        out_ready = 1'b0;
        drive_op(0, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle();
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_op1", out_op1, 32'd0);
        check("arst_out_op2", out_op2, 32'd0);
        check("arst_out_instr", out_instr, 32'd0);
        check("arst_out_rd", out_rd, 5'd0);
        check("arst_out_rd_we", out_rd_we, 1'b0);
        check("arst_stall_count", stall_count, 16'd0);
        check("arst_fsm_state", fsm_state, EMPTY);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        drive_op(1, 11, 0, 14, 1, 0, 0, 32'h00058713);
        #1;
        check("post_reset_ready", in_ready, 1'b1);
        cycle();
        check("post_reset_valid", out_valid, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive_op($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
            drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 39) == 0;
            cycle();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
